// File: rtl/teclado_pkg.sv
// Shared types and helpers for the keypad front end.
// Also defines the lowest-index priority helpers used by the top level.
package teclado_pkg;
   localparam int         N_TECLAS    = 7;
   localparam logic [2:0] IDX_NINGUNA = 3'd7;

   typedef logic [N_TECLAS-1:0] teclas_t;

   // One-hot of the lowest set bit; zero when nothing is set.
   function automatic teclas_t prioridad(teclas_t v);
      teclas_t r;
      r = '0;
      for (int i = N_TECLAS - 1; i >= 0; i--) begin
         if (v[i]) r = teclas_t'(1) << i;
      end
      return r;
   endfunction

   function automatic logic [2:0] indice(teclas_t v);
      logic [2:0] r;
      r = IDX_NINGUNA;
      for (int i = N_TECLAS - 1; i >= 0; i--) begin
         if (v[i]) r = 3'(i);
      end
      return r;
   endfunction
endpackage

// File: rtl/teclado_debounce_if.sv
// Key bus between the raw keypad side and the debounced note-request side.
interface teclado_debounce_if;
   import teclado_pkg::*;

   teclas_t    teclas_in;
   teclas_t    teclas;
   logic [2:0] tecla_idx;
   logic       nota_valida;
   logic       pulso_tecla;

   modport master (output teclas_in, input teclas, tecla_idx, nota_valida, pulso_tecla);
   modport slave  (input teclas_in, output teclas, tecla_idx, nota_valida, pulso_tecla);
endinterface

// File: rtl/antirrebote_bit.sv
// One key: 2-FF synchroniser, stability counter and accepted-level flop.
module antirrebote_bit #(
   parameter int DEBOUNCE_CYCLES = 1000000
) (
   input  logic clk,
   input  logic reset,
   input  logic tecla_in,
   output logic estable
);
   localparam int            CW         = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] CUENTA_FIN = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1_q, sync1_d;
   logic          sync2_q, sync2_d;
   logic          estable_q, estable_d;
   logic [CW-1:0] cuenta_q, cuenta_d;

   always_comb begin
      sync1_d   = tecla_in;
      sync2_d   = sync1_q;
      estable_d = estable_q;
      cuenta_d  = '0;
      // Any return to the accepted level before terminal count restarts the wait.
      if (sync2_q != estable_q) begin
         if (cuenta_q == CUENTA_FIN) begin
            estable_d = sync2_q;
         end else begin
            cuenta_d = cuenta_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1_q   <= 1'b0;
         sync2_q   <= 1'b0;
         estable_q <= 1'b0;
         cuenta_q  <= '0;
      end else begin
         sync1_q   <= sync1_d;
         sync2_q   <= sync2_d;
         estable_q <= estable_d;
         cuenta_q  <= cuenta_d;
      end
   end

   assign estable = estable_q;
endmodule

// File: rtl/teclado_debounce.sv
// Keypad front end: per-key debounce, registered priority encoder, new-note pulse.
// Optional TECLA_LATCH_EN: accepted presses latch (toggle on same key) instead of momentary.
module teclado_debounce
   import teclado_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1000000
) (
   input  logic              clk,
   input  logic              reset,
   teclado_debounce_if.slave bus
);
   teclas_t    estable;
   teclas_t    teclas_q, teclas_d;
   logic [2:0] idx_q, idx_d;
   logic       pulso_q, pulso_d;

   for (genvar g = 0; g < N_TECLAS; g++) begin : g_tecla
      antirrebote_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_bit (
         .clk      (clk),
         .reset    (reset),
         .tecla_in (bus.teclas_in[g]),
         .estable  (estable[g])
      );
   end

`ifdef TECLA_LATCH_EN
   teclas_t estable_prev_q;
   teclas_t ganadora;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) estable_prev_q <= '0;
      else        estable_prev_q <= estable;
   end

   // Only freshly accepted presses act; pressing the latched key again clears it.
   always_comb begin
      ganadora = prioridad(estable & ~estable_prev_q);
      teclas_d = teclas_q;
      if (ganadora != '0) begin
         teclas_d = (ganadora == teclas_q) ? '0 : ganadora;
      end
   end
`else
   always_comb begin
      teclas_d = prioridad(estable);
   end
`endif

   always_comb begin
      idx_d   = indice(teclas_d);
      pulso_d = (teclas_d != '0) && (teclas_d != teclas_q);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         teclas_q <= '0;
         idx_q    <= IDX_NINGUNA;
         pulso_q  <= 1'b0;
      end else begin
         teclas_q <= teclas_d;
         idx_q    <= idx_d;
         pulso_q  <= pulso_d;
      end
   end

   assign bus.teclas      = teclas_q;
   assign bus.tecla_idx   = idx_q;
   assign bus.nota_valida = (teclas_q != '0);
   assign bus.pulso_tecla = pulso_q;
endmodule

// File: tb/tb_teclado_debounce.sv
// Self-checking bench for teclado_debounce with a short debounce window.
module tb_teclado_debounce;
   import teclado_pkg::*;

   localparam int DC = 16;

   logic clk;
   logic reset;
   int   errors;
   int   checks;

   teclado_debounce_if bus ();

   teclado_debounce #(.DEBOUNCE_CYCLES(DC)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   // Reference: a key's accepted level flips once its twice-delayed input
   // has disagreed with it for DC consecutive clocks; outputs lag one clock.
   teclas_t    m_d1, m_d2, m_est, m_prev, m_teclas;
   logic [2:0] m_idx;
   logic       m_pulso;
   int         m_run [N_TECLAS];

   function automatic teclas_t menor(teclas_t v);
      teclas_t w;
      w = '0;
      for (int i = 0; i < N_TECLAS; i++) begin
         if (v[i]) begin
            w = teclas_t'(1 << i);
            break;
         end
      end
      return w;
   endfunction

   always @(posedge clk or negedge reset) begin
      teclas_t nuevo;
      if (!reset) begin
         m_d1 = '0; m_d2 = '0; m_est = '0; m_prev = '0;
         m_teclas = '0; m_idx = 3'd7; m_pulso = 1'b0;
         for (int k = 0; k < N_TECLAS; k++) m_run[k] = 0;
      end else begin
`ifdef TECLA_LATCH_EN
         nuevo = menor(m_est & ~m_prev);
         if (nuevo == '0)           nuevo = m_teclas;
         else if (nuevo == m_teclas) nuevo = '0;
         m_prev = m_est;
`else
         nuevo = menor(m_est);
`endif
         m_pulso  = (nuevo != '0) && (nuevo != m_teclas);
         m_teclas = nuevo;
         m_idx    = (nuevo == '0) ? 3'd7 : 3'($clog2(nuevo));
         for (int k = 0; k < N_TECLAS; k++) begin
            if (m_d2[k] != m_est[k]) begin
               m_run[k]++;
               if (m_run[k] == DC) begin
                  m_est[k] = m_d2[k];
                  m_run[k] = 0;
               end
            end else begin
               m_run[k] = 0;
            end
         end
         m_d2 = m_d1;
         m_d1 = bus.teclas_in;
      end
   end

   logic [11:0] got, exp;

   task automatic test_reset();
      reset = 1'b0;
      bus.teclas_in = 7'h7F;
      for (int n = 0; n < 6; n++) begin
         @(negedge clk);
         checks++;
         if (bus.teclas !== 7'd0 || bus.tecla_idx !== 3'd7 || bus.nota_valida !== 1'b0 || bus.pulso_tecla !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold n=%0d got teclas=%b idx=%0d nv=%b p=%b exp 0/7/0/0", n,
                     bus.teclas, bus.tecla_idx, bus.nota_valida, bus.pulso_tecla);
         end
      end
      bus.teclas_in = '0;
      @(negedge clk);
      reset = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_press();
      bus.teclas_in = 7'b0000100;
      for (int n = 1; n <= 24; n++) begin
         @(negedge clk);
         got = {bus.teclas, bus.tecla_idx, bus.nota_valida, bus.pulso_tecla};
         exp = (n >= 19) ? {7'b0000100, 3'd2, 1'b1, n == 19} : {7'd0, 3'd7, 1'b0, 1'b0};
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL press_latency n=%0d got=%h exp=%h", n, got, exp);
         end
      end
   endtask

   task automatic test_bounce();
      int pulsos;
      bus.teclas_in = '0;
      for (int n = 1; n <= 22; n++) begin
         @(negedge clk);
         got = {bus.teclas, bus.tecla_idx, bus.nota_valida, bus.pulso_tecla};
         exp = {m_teclas, m_idx, m_teclas != '0, m_pulso};
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL release_model n=%0d got=%h exp=%h", n, got, exp);
         end
      end
      pulsos = 0;
      bus.teclas_in = 7'b0000001;
      for (int n = 1; n <= 26; n++) begin
         @(negedge clk);
         if (n == 5) bus.teclas_in = '0;
         if (bus.pulso_tecla === 1'b1) pulsos++;
`ifndef TECLA_LATCH_EN
         checks++;
         if (bus.teclas !== 7'd0) begin
            errors++;
            $display("FAIL bounce_teclas n=%0d got=%b exp=0000000", n, bus.teclas);
         end
`endif
      end
      checks++;
      if (pulsos !== 0) begin
         errors++;
         $display("FAIL bounce_pulse got=%0d pulses exp=0", pulsos);
      end
   endtask

   task automatic test_simultaneous();
      int pulsos;
      pulsos = 0;
      bus.teclas_in = 7'b0101000;
      for (int n = 1; n <= 22; n++) begin
         @(negedge clk);
         if (bus.pulso_tecla === 1'b1) pulsos++;
         got = {bus.teclas, bus.tecla_idx, bus.nota_valida, bus.pulso_tecla};
         exp = {m_teclas, m_idx, m_teclas != '0, m_pulso};
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL simul_model n=%0d got=%h exp=%h", n, got, exp);
         end
      end
`ifndef TECLA_LATCH_EN
      checks++;
      if (bus.teclas !== 7'b0001000 || bus.tecla_idx !== 3'd3 || pulsos !== 1) begin
         errors++;
         $display("FAIL simul_winner got teclas=%b idx=%0d pulses=%0d exp 0001000/3/1", bus.teclas, bus.tecla_idx, pulsos);
      end
      bus.teclas_in = 7'b0100000;
      for (int n = 1; n <= 22; n++) begin
         @(negedge clk);
         got = {bus.teclas, bus.tecla_idx, bus.nota_valida, bus.pulso_tecla};
         exp = (n >= 19) ? {7'b0100000, 3'd5, 1'b1, n == 19} : {7'b0001000, 3'd3, 1'b1, 1'b0};
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL handover n=%0d got=%h exp=%h", n, got, exp);
         end
      end
`endif
   endtask

   task automatic test_reset_mid();
      bus.teclas_in = 7'b1000000;
      repeat (22) @(negedge clk);
      bus.teclas_in = 7'b1000010;
      repeat (12) @(negedge clk);
      reset = 1'b0;
      #1;
      checks++;
      if (bus.teclas !== 7'd0 || bus.tecla_idx !== 3'd7 || bus.nota_valida !== 1'b0 || bus.pulso_tecla !== 1'b0) begin
         errors++;
         $display("FAIL async_reset got teclas=%b idx=%0d nv=%b p=%b exp 0/7/0/0",
                  bus.teclas, bus.tecla_idx, bus.nota_valida, bus.pulso_tecla);
      end
      @(negedge clk);
      reset = 1'b1;
      for (int n = 1; n <= 22; n++) begin
         @(negedge clk);
         got = {bus.teclas, bus.tecla_idx, bus.nota_valida, bus.pulso_tecla};
         exp = (n >= 19) ? {7'b0000010, 3'd1, 1'b1, n == 19} : {7'd0, 3'd7, 1'b0, 1'b0};
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL reset_restart n=%0d got=%h exp=%h", n, got, exp);
         end
      end
   endtask

`ifdef TECLA_LATCH_EN
   task automatic test_latch();
      teclas_t    pasos  [6] = '{7'b0010000, 7'd0, 7'b0010000, 7'd0, 7'b1000000, 7'd0};
      teclas_t    espera [6] = '{7'b0010000, 7'b0010000, 7'd0, 7'd0, 7'b1000000, 7'b1000000};
      int         pulsos_esp [6] = '{1, 0, 0, 0, 1, 0};
      int         pulsos;
      bus.teclas_in = '0;
      repeat (22) @(negedge clk);
      for (int s = 0; s < 6; s++) begin
         pulsos = 0;
         bus.teclas_in = pasos[s];
         for (int n = 1; n <= 22; n++) begin
            @(negedge clk);
            if (bus.pulso_tecla === 1'b1) pulsos++;
         end
         checks++;
         if (bus.teclas !== espera[s] || pulsos !== pulsos_esp[s]) begin
            errors++;
            $display("FAIL latch step=%0d got teclas=%b pulses=%0d exp %b/%0d", s, bus.teclas, pulsos, espera[s], pulsos_esp[s]);
         end
      end
   endtask
`endif

   task automatic test_random();
      int hold;
      hold = 0;
      for (int n = 0; n < 1500; n++) begin
         @(negedge clk);
         got = {bus.teclas, bus.tecla_idx, bus.nota_valida, bus.pulso_tecla};
         exp = {m_teclas, m_idx, m_teclas != '0, m_pulso};
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL random_model n=%0d in=%b got=%h exp=%h", n, bus.teclas_in, got, exp);
         end
         if (hold == 0) begin
            case ($urandom_range(0, 3))
               0:       bus.teclas_in = teclas_t'($urandom);
               1:       bus.teclas_in = '0;
               default: bus.teclas_in = bus.teclas_in ^ teclas_t'(1 << $urandom_range(0, N_TECLAS - 1));
            endcase
            hold = (($urandom & 1) != 0) ? $urandom_range(1, 8) : $urandom_range(17, 30);
         end else begin
            hold--;
         end
      end
   endtask

   initial begin
      errors = 0;
      checks = 0;
      bus.teclas_in = '0;
      test_reset();
      test_press();
      test_bounce();
      test_simultaneous();
      test_reset_mid();
`ifdef TECLA_LATCH_EN
      test_latch();
`endif
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
